// File: rtl/palette_sequencer_pkg.sv
// Shared definitions for the palette sequencer: palette geometry, named
// colour indices, pending-counter sizing, the sequencer FSM encoding and a
// saturating add used by the pending-event counter.
package palette_sequencer_pkg;

  localparam int NUM_COLORS = 8;
  localparam int INDEX_W    = 3;
  localparam int CNT_MAX    = 7;
  localparam int CNT_W      = 3;
  localparam int TIMER_W    = 10;

  // Colour name to palette index.
  localparam logic [INDEX_W-1:0] CYAN   = 3'd0;
  localparam logic [INDEX_W-1:0] PINK   = 3'd1;
  localparam logic [INDEX_W-1:0] GREEN  = 3'd2;
  localparam logic [INDEX_W-1:0] ORANGE = 3'd3;
  localparam logic [INDEX_W-1:0] PURPLE = 3'd4;
  localparam logic [INDEX_W-1:0] YELLOW = 3'd5;
  localparam logic [INDEX_W-1:0] RED    = 3'd6;
  localparam logic [INDEX_W-1:0] WHITE  = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    COMMIT = 2'd2
  } seq_state_e;

  // Add 0..3 new events to the pending count, clamping at CNT_MAX.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
    if (sum > (CNT_W+1)'(CNT_MAX)) begin
      return CNT_W'(CNT_MAX);
    end else begin
      return sum[CNT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/palette_sequencer_auto_cycle_timer.sv
// Auto-cycle frame timer. Counts frame_start pulses while auto_en is high and
// raises auto_tick on every AUTO_FRAMES-th pulse (the pulse that finds the
// counter at AUTO_FRAMES-1, which then wraps to 0).
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   frame_start  one-cycle frame boundary pulse
//   auto_en      level enable; low clears the counter
//   auto_tick    combinational one-cycle tick, coincident with frame_start
module auto_cycle_timer
  import palette_sequencer_pkg::*;
#(
  parameter int AUTO_FRAMES = 120
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_start,
  input  logic auto_en,
  output logic auto_tick
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(AUTO_FRAMES - 1);

  logic [TIMER_W-1:0] frame_cnt_r;

  // Frame counter; disabled timer restarts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_r <= 10'd0;
    end else if (!auto_en) begin
      frame_cnt_r <= 10'd0;
    end else if (frame_start) begin
      frame_cnt_r <= (frame_cnt_r == LAST) ? 10'd0 : frame_cnt_r + 10'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  assign auto_tick = auto_en && frame_start && (frame_cnt_r == LAST);

endmodule

// File: rtl/palette_sequencer.sv
// Palette sequencer: collects colour-change events (bounce, button, auto
// timer), accumulates them in a saturating pending counter and commits the
// accumulated step to the colour index only at frame boundaries.
// Ports:
//   clk, rst     pixel clock, synchronous active-high reset
//   frame_start  one-cycle pulse at start of vertical blanking
//   bounce       one-cycle pulse on any edge hit
//   btn_next     one-cycle debounced button pulse
//   auto_en      enables the auto-cycle timer
//   freeze       holds the colour, discards and clears pending events
//   color_index  registered palette index
//   changed      one-cycle pulse when color_index takes a new value
//   pending      high while the pending count is nonzero
module palette_sequencer
  import palette_sequencer_pkg::*;
#(
  parameter int AUTO_FRAMES = 120
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               bounce,
  input  logic               btn_next,
  input  logic               auto_en,
  input  logic               freeze,
  output logic [INDEX_W-1:0] color_index,
  output logic               changed,
  output logic               pending
);

  seq_state_e         state_r, state_s;
  logic [CNT_W-1:0]   count_r, count_s;
  logic [CNT_W-1:0]   step_r;
  logic [INDEX_W-1:0] color_index_r;
  logic               changed_r;
  logic               auto_tick_s;
  logic [1:0]         event_sum_s;
  logic               capture_s;

  auto_cycle_timer #(
    .AUTO_FRAMES (AUTO_FRAMES)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .auto_en     (auto_en),
    .auto_tick   (auto_tick_s)
  );

  // Events this cycle; freeze discards them all.
  assign event_sum_s = freeze ? 2'd0
                              : ({1'b0, bounce} + {1'b0, btn_next} + {1'b0, auto_tick_s});

  // A frame boundary in ARMED snapshots the count; the coincident events
  // are not part of the snapshot and instead reload the counter.
  assign capture_s = (state_r == ARMED) && frame_start && !freeze;

  // Next pending count and next FSM state.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    if (freeze) begin
      count_s = 3'd0;
    end else if (capture_s) begin
      count_s = {1'b0, event_sum_s};
    end else begin
      count_s = sat_add(count_r, event_sum_s);
    end

    case (state_r)
      IDLE: begin
        if (count_s != 3'd0) begin
          state_s = ARMED;
        end else begin
          state_s = IDLE;
        end
      end
      ARMED: begin
        if (capture_s) begin
          state_s = COMMIT;
        end else if (count_s == 3'd0) begin
          state_s = IDLE;
        end else begin
          state_s = ARMED;
        end
      end
      COMMIT: begin
        if (count_s != 3'd0) begin
          state_s = ARMED;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counter, step capture and registered colour outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      count_r       <= 3'd0;
      step_r        <= 3'd0;
      color_index_r <= CYAN;
      changed_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      step_r  <= capture_s ? count_r : step_r;
      // A freeze raised during the commit cycle still holds the colour.
      if ((state_r == COMMIT) && !freeze) begin
        color_index_r <= color_index_r + INDEX_W'(step_r);
        changed_r     <= 1'b1;
      end else begin
        color_index_r <= color_index_r;
        changed_r     <= 1'b0;
      end
    end
  end

  assign color_index = color_index_r;
  assign changed     = changed_r;
  assign pending     = (count_r != 3'd0);

endmodule

// File: tb/tb_palette_sequencer.sv
// Directed self-checking bench for palette_sequencer (AUTO_FRAMES=4).
module tb_palette_sequencer;
  import palette_sequencer_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               frame_start = 1'b0;
  logic               bounce = 1'b0;
  logic               btn_next = 1'b0;
  logic               auto_en = 1'b0;
  logic               freeze = 1'b0;
  logic [INDEX_W-1:0] color_index;
  logic               changed;
  logic               pending;

  int tests_run = 0;
  int tests_failed = 0;
  int chg_cnt = 0;
  int chg_base = 0;

  palette_sequencer #(.AUTO_FRAMES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .bounce      (bounce),
    .btn_next    (btn_next),
    .auto_en     (auto_en),
    .freeze      (freeze),
    .color_index (color_index),
    .changed     (changed),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  // Count changed pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (changed) chg_cnt <= chg_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // frame_start pulse followed by n idle cycles.
  task automatic frame_then(input int n);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (n) tick();
  endtask

  task automatic bounces(input int n);
    bounce = 1'b1;
    repeat (n) tick();
    bounce = 1'b0;
  endtask

  initial begin
    // Reset
    tick(); tick();
    rst = 1'b0;
    check("rst_index", color_index, 0);
    check("rst_changed", changed, 0);
    check("rst_pending", pending, 0);
    check("rst_state", 32'(dut.state_r), 32'(IDLE));

    // Single bounce, commit on frame
    bounces(1);
    check("t1_pending_set", pending, 1);
    check("t1_index_hold", color_index, 0);
    frame_then(0);
    check("t1_pending_clr", pending, 0);
    check("t1_no_early_change", changed, 0);
    tick();
    check("t1_index", color_index, 1);
    check("t1_changed", changed, 1);
    tick();
    check("t1_changed_once", changed, 0);

    // Move to index 6, then bounce+button same cycle -> step 2, wraps to 0
    bounces(5);
    frame_then(2);
    check("t2_index6", color_index, 6);
    chg_base = chg_cnt;
    bounce = 1'b1; btn_next = 1'b1;
    tick();
    bounce = 1'b0; btn_next = 1'b0;
    frame_then(1);
    check("t2_wrap", color_index, 0);
    check("t2_changed", changed, 1);
    tick(); tick();
    check("t2_one_pulse", chg_cnt - chg_base, 1);

    // Saturation: 10 events commit as step 7
    bounces(10);
    check("t3_pending", pending, 1);
    check("t3_count_sat", 32'(dut.count_r), 7);
    frame_then(1);
    check("t3_index", color_index, 7);

    // Bounce coincident with frame_start while ARMED (count=1)
    tick();
    chg_base = chg_cnt;
    bounces(1);
    bounce = 1'b1; frame_start = 1'b1;
    tick();
    bounce = 1'b0; frame_start = 1'b0;
    tick();
    check("t4_first_step", color_index, 0);
    check("t4_still_pending", pending, 1);
    tick(); tick();
    check("t4_held", color_index, 0);
    frame_then(1);
    check("t4_second_step", color_index, 1);
    tick(); tick();
    check("t4_two_pulses", chg_cnt - chg_base, 2);

    // Auto-cycle, AUTO_FRAMES=4: tick on 4th/8th pulse, commit next pulse
    auto_en = 1'b1;
    repeat (3) frame_then(3);
    check("t5_no_tick_yet", pending, 0);
    frame_then(3);
    check("t5_tick4_pending", pending, 1);
    check("t5_tick4_index", color_index, 1);
    frame_then(3);
    check("t5_commit5", color_index, 2);
    repeat (3) frame_then(3);
    check("t5_tick8_index", color_index, 2);
    check("t5_tick8_pending", pending, 1);
    frame_then(3);
    check("t5_commit9", color_index, 3);

    // Restart timer, then freeze from the 3rd pulse onward
    auto_en = 1'b0;
    tick();
    auto_en = 1'b1;
    chg_base = chg_cnt;
    repeat (2) frame_then(3);
    freeze = 1'b1;
    for (int i = 3; i <= 12; i++) begin
      frame_then(3);
      check("t5_freeze_pending", pending, 0);
    end
    bounces(2);
    check("t5_freeze_drop_evt", pending, 0);
    check("t5_freeze_index", color_index, 3);
    check("t5_freeze_nochg", chg_cnt - chg_base, 0);
    freeze = 1'b0;
    auto_en = 1'b0;
    tick();

    // Reset while in COMMIT
    bounces(1);
    frame_then(0);
    check("t6_in_commit", 32'(dut.state_r), 32'(COMMIT));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_index", color_index, 0);
    check("t6_changed", changed, 0);
    check("t6_pending", pending, 0);
    check("t6_state", 32'(dut.state_r), 32'(IDLE));
    tick();
    check("t6_no_late_change", changed, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
